// File: rtl/cpu_pkg.sv
// +-----------------------------------------------------------------------------+
// | cpu_pkg : shared instruction width, opcode encoding and field-slice helpers |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

   localparam int INSTR_W = 16;

   // Opcodes at or above this value have no decoder entry.
   localparam logic [3:0] OPCODE_ILLEGAL_MIN = 4'hC;

   typedef enum logic [3:0] {
      LW   = 4'h0,
      SW   = 4'h1,
      ADD  = 4'h2,
      ADDI = 4'h3,
      AND  = 4'h4,
      ANDI = 4'h5,
      OR   = 4'h6,
      XOR  = 4'h7,
      SRAI = 4'h8,
      SLLI = 4'h9,
      BR0  = 4'hA,
      BR1  = 4'hB
   } opcode_t;

   function automatic logic [3:0] get_opcode(input logic [INSTR_W-1:0] instr);
      return instr[15:12];
   endfunction

   function automatic logic [6:0] get_immediate(input logic [INSTR_W-1:0] instr);
      return instr[6:0];
   endfunction

   function automatic logic [5:0] get_nzimm(input logic [INSTR_W-1:0] instr);
      return instr[5:0];
   endfunction

   function automatic logic [8:0] get_offset(input logic [INSTR_W-1:0] instr);
      return instr[8:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +-----------------------------------------------------------------------------+
// | fetch_fifo : synchronous show-ahead FIFO with flush (DEPTH power of 2)      |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the head is only observed when count is non-zero.
   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// +-----------------------------------------------------------------------------+
// | instruction_fetch : credit-based prefetch with redirect flush               |
// | Optional: IFETCH_ILLEGAL_EN enables the if_illegal opcode check. Rev 1.0    |
// +-----------------------------------------------------------------------------+
`default_nettype none

module instruction_fetch
   import cpu_pkg::*;
#(
   parameter int                ADDR_W     = 16,
   parameter int                FIFO_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               if_valid,
   input  logic               if_ready,
   output logic [INSTR_W-1:0] if_instr,
   output logic [ADDR_W-1:0]  if_pc,
   output logic [3:0]         if_opcode,
   output logic [6:0]         if_immediate,
   output logic [5:0]         if_nzimm,
   output logic [8:0]         if_offset,
   output logic               if_illegal
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int EW = ADDR_W + INSTR_W;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]     outstanding_q, outstanding_d;
   logic [CW-1:0]     discard_q, discard_d;

   logic [CW-1:0]     fifo_count;
   logic              fifo_full, fifo_empty;
   logic [EW-1:0]     fifo_head;
   logic [CW:0]       credit_used;
   logic              issue, rsp_ok, rsp_drop, push, pop;
   logic [ADDR_W-1:0] redirect_aligned;

   assign redirect_aligned = redirect_pc & {{(ADDR_W-1){1'b1}}, 1'b0};
   assign credit_used      = {1'b0, fifo_count} + {1'b0, outstanding_q};
   assign issue    = rst_n && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH));
   assign rsp_ok   = imem_rvalid && (outstanding_q != '0);
   assign rsp_drop = rsp_ok && (discard_q != '0);
   assign push     = rsp_ok && !rsp_drop && !redirect_valid;
   assign pop      = if_valid && if_ready;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q + CW'(issue) - CW'(rsp_ok);
      discard_d     = discard_q - CW'(rsp_drop);
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_W'(2);
      if (push)  resp_pc_d  = resp_pc_q + ADDR_W'(2);
      if (redirect_valid) begin
         fetch_pc_d = redirect_aligned;
         resp_pc_d  = redirect_aligned;
         // Every request still in flight after this edge predates the redirect.
         discard_d  = outstanding_q - CW'(rsp_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  ({resp_pc_q, imem_rdata}),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .data_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign imem_req     = issue;
   assign imem_addr    = fetch_pc_q;
   assign if_valid     = !fifo_empty;
   assign if_instr     = if_valid ? fifo_head[INSTR_W-1:0] : '0;
   assign if_pc        = if_valid ? fifo_head[EW-1:INSTR_W] : '0;
   assign if_opcode    = get_opcode(if_instr);
   assign if_immediate = get_immediate(if_instr);
   assign if_nzimm     = get_nzimm(if_instr);
   assign if_offset    = get_offset(if_instr);

`ifdef IFETCH_ILLEGAL_EN
   assign if_illegal = if_valid && (if_opcode >= OPCODE_ILLEGAL_MIN);
`else
   assign if_illegal = 1'b0;
`endif

   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
      imem_rvalid |-> (outstanding_q != '0));
   a_out_bound: assert property (@(posedge clk) disable iff (!rst_n)
      (outstanding_q <= CW'(FIFO_DEPTH)) && (discard_q <= CW'(FIFO_DEPTH)));
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && fifo_full && !pop));

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// +-----------------------------------------------------------------------------+
// | tb_instruction_fetch : directed bench with a variable-latency memory model  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_instruction_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        redirect_valid;
   logic [15:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [15:0] if_instr;
   logic [15:0] if_pc;
   logic [3:0]  if_opcode;
   logic [6:0]  if_immediate;
   logic [5:0]  if_nzimm;
   logic [8:0]  if_offset;
   logic        if_illegal;

   int checks = 0;
   int errors = 0;
   int lat    = 1;
   int nreq;

`ifdef IFETCH_ILLEGAL_EN
   localparam logic ILL_EXP = 1'b1;
`else
   localparam logic ILL_EXP = 1'b0;
`endif

   always #5 clk = ~clk;

   instruction_fetch dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_opcode      (if_opcode),
      .if_immediate   (if_immediate),
      .if_nzimm       (if_nzimm),
      .if_offset      (if_offset),
      .if_illegal     (if_illegal)
   );

   // Instruction memory: 128 words, fixed latency of 1..3 cycles.
   logic [15:0] mem [128];
   logic [2:0]  s_v;
   logic [15:0] s_d [3];

   always @(posedge clk) begin
      if (!rst_n) s_v <= '0;
      else        s_v <= {s_v[1:0], imem_req};
      s_d[0] <= mem[imem_addr[7:1]];
      s_d[1] <= s_d[0];
      s_d[2] <= s_d[1];
   end

   assign imem_rvalid = s_v[lat-1];
   assign imem_rdata  = s_d[lat-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset(input int latency);
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      lat            = latency;
      repeat (3) tick();
   endtask

   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget && !if_valid; i++) tick();
      check("wait_valid", {31'b0, if_valid}, 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = 16'h1000 | 16'(i * 2);
      mem[0]    = 16'h2123;
      mem[1]    = 16'h3045;
      mem[2]    = 16'h4067;
      mem[3]    = 16'h5089;
      mem[7'h40] = 16'hA1FF;
      mem[7'h41] = 16'hC000;
      mem[7'h42] = 16'hB000;
      redirect_pc = '0;
      if_ready    = 1'b0;

      // Reset state
      do_reset(1);
      check("rst_req",   {31'b0, imem_req}, 32'd0);
      check("rst_valid", {31'b0, if_valid}, 32'd0);
      check("rst_instr", {16'b0, if_instr}, 32'd0);
      check("rst_pc",    {16'b0, if_pc},    32'd0);
      check("rst_ill",   {31'b0, if_illegal}, 32'd0);
      if_ready = 1'b1;
      rst_n    = 1'b1;
      #1;
      check("first_req",  {31'b0, imem_req}, 32'd1);
      check("first_addr", {16'b0, imem_addr}, 32'h0000);

      // Streaming at latency 1
      tick();
      check("second_addr",  {16'b0, imem_addr}, 32'h0002);
      check("valid_lat1",   {31'b0, if_valid}, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check("stream_valid", {31'b0, if_valid}, 32'd1);
         check("stream_pc",    {16'b0, if_pc}, 32'(i * 2));
         check("stream_instr", {16'b0, if_instr}, {16'b0, mem[i]});
         tick();
      end

      // Backpressure: credit limit stops issue at FIFO_DEPTH
      if_ready = 1'b0;
      do_reset(1);
      rst_n = 1'b1;
      #1;
      nreq = 0;
      for (int i = 0; i < 10; i++) begin
         if (imem_req) nreq++;
         tick();
      end
      check("bp_nreq",   32'(nreq), 32'd4);
      check("bp_req_lo", {31'b0, imem_req}, 32'd0);
      if_ready = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         check("bp_pc",    {16'b0, if_pc}, 32'(i * 2));
         check("bp_instr", {16'b0, if_instr}, {16'b0, mem[i]});
         tick();
      end

      // Redirect with two requests in flight (latency 3)
      do_reset(3);
      rst_n = 1'b1;
      tick();
      tick();
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0041;
      #1;
      check("redir_req", {31'b0, imem_req}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      #1;
      check("redir_addr", {16'b0, imem_addr}, 32'h0040);
      for (int i = 0; i < 4; i++) begin
         check("redir_gap", {31'b0, if_valid}, 32'd0);
         tick();
      end
      check("redir_valid", {31'b0, if_valid}, 32'd1);
      check("redir_pc0",   {16'b0, if_pc}, 32'h0040);
      check("redir_i0",    {16'b0, if_instr}, 32'h1040);
      tick();
      check("redir_pc1",   {16'b0, if_pc}, 32'h0042);
      check("redir_i1",    {16'b0, if_instr}, 32'h1042);

      // Field split and illegal-opcode flag
      if_ready = 1'b0;
      do_reset(1);
      rst_n          = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 16'h0080;
      #1;
      check("f_req", {31'b0, imem_req}, 32'd0);
      tick();
      redirect_valid = 1'b0;
      wait_valid(10);
      check("f_pc",     {16'b0, if_pc}, 32'h0080);
      check("f_instr",  {16'b0, if_instr}, 32'hA1FF);
      check("f_opcode", {28'b0, if_opcode}, 32'hA);
      check("f_offset", {23'b0, if_offset}, 32'h1FF);
      check("f_imm",    {25'b0, if_immediate}, 32'h7F);
      check("f_nzimm",  {26'b0, if_nzimm}, 32'h3F);
      check("f_ill_a",  {31'b0, if_illegal}, 32'd0);
      if_ready = 1'b1;
      tick();
      check("f_pc_c",   {16'b0, if_pc}, 32'h0082);
      check("f_ill_c",  {31'b0, if_illegal}, {31'b0, ILL_EXP});
      tick();
      check("f_pc_b",   {16'b0, if_pc}, 32'h0084);
      check("f_ill_b",  {31'b0, if_illegal}, 32'd0);

      // Redirect while valid: flush, and fetch PC wrap-around
      redirect_valid = 1'b1;
      redirect_pc    = 16'hFFFE;
      tick();
      redirect_valid = 1'b0;
      #1;
      check("w_flush",  {31'b0, if_valid}, 32'd0);
      check("w_req",    {31'b0, imem_req}, 32'd1);
      check("w_addr0",  {16'b0, imem_addr}, 32'hFFFE);
      tick();
      check("w_addr1",  {16'b0, imem_addr}, 32'h0000);
      wait_valid(10);
      check("w_pc0",    {16'b0, if_pc}, 32'hFFFE);
      check("w_i0",     {16'b0, if_instr}, 32'h10FE);
      tick();
      check("w_pc1",    {16'b0, if_pc}, 32'h0000);
      check("w_i1",     {16'b0, if_instr}, 32'h2123);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
